// File: rtl/prio_arb_lock_pkg.sv
// Shared types and width helper for the locking priority arbiter.
package prio_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_arb_lock_if.sv
// Request/grant bundle between the bus masters and the locking arbiter.
interface prio_arb_lock_if
    import prio_arb_pkg::*;
#(
    parameter int N = 8
);
    localparam int IDXW = idx_w(N);

    logic [N-1:0]    req;
    logic            done;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    gnt_onehot;
    logic            any_req;

    modport master (
        output req, done,
        input  gnt_valid, gnt_idx, gnt_onehot, any_req
    );

    modport slave (
        input  req, done,
        output gnt_valid, gnt_idx, gnt_onehot, any_req
    );
endinterface

// File: rtl/prio_arb_lock_enc.sv
// Combinational N-input priority encoder; search begins at off and wraps modulo N.
module prio_enc_param
    import prio_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = idx_w(N)
) (
    input  logic [N-1:0]    vec,
    input  logic [IDXW-1:0] off,
    output logic [IDXW-1:0] idx,
    output logic            found
);
    // Scan from the far end so the nearest set bit at or after off is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (vec[(int'(off) + k) % N]) begin
                idx   = IDXW'((int'(off) + k) % N);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/prio_arb_lock.sv
// Locking N-requester arbiter: grant is held until the owner pulses done.
// Define PRIO_ARB_ROUND_ROBIN_EN for rotating priority; default is lowest-index-wins.
module prio_arb_lock
    import prio_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    prio_arb_lock_if.slave   bus
);
    state_t          state, state_d;
    logic [IDXW-1:0] win_idx;
    logic            win_found;
    logic            load, release_gnt;

    logic            gnt_valid_q;
    logic [IDXW-1:0] gnt_idx_q;
    logic [N-1:0]    gnt_onehot_q;
    logic            any_req_q;
    logic [IDXW-1:0] start_off;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] rr_ptr;
    assign start_off = rr_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (load)
            rr_ptr <= (win_idx == IDXW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
`else
    assign start_off = '0;
`endif

    prio_enc_param #(.N(N), .IDXW(IDXW)) u_enc (
        .vec   (bus.req),
        .off   (start_off),
        .idx   (win_idx),
        .found (win_found)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // done only matters while a grant is held; it both releases and re-arbitrates.
    always_comb begin
        state_d     = state;
        load        = 1'b0;
        release_gnt = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    load    = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.done) begin
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        release_gnt = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            any_req_q    <= 1'b0;
        end else begin
            any_req_q <= |bus.req;
            if (load) begin
                gnt_valid_q  <= 1'b1;
                gnt_idx_q    <= win_idx;
                gnt_onehot_q <= N'(1) << win_idx;
            end else if (release_gnt) begin
                gnt_valid_q  <= 1'b0;
                gnt_onehot_q <= '0;
            end
        end
    end

    assign bus.gnt_valid  = gnt_valid_q;
    assign bus.gnt_idx    = gnt_idx_q;
    assign bus.gnt_onehot = gnt_onehot_q;
    assign bus.any_req    = any_req_q;
endmodule

// File: tb/tb_prio_arb_lock.sv
// Directed bench for prio_arb_lock at N=8 and N=5, in either priority mode.
module tb_prio_arb_lock;
    import prio_arb_pkg::*;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    prio_arb_lock_if #(.N(8)) bus8 ();
    prio_arb_lock_if #(.N(5)) bus5 ();

    prio_arb_lock #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    prio_arb_lock #(.N(5)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] oh);
        chk({tag, ".valid"},  64'(bus8.gnt_valid),  64'(v));
        chk({tag, ".idx"},    64'(bus8.gnt_idx),    64'(idx));
        chk({tag, ".onehot"}, 64'(bus8.gnt_onehot), 64'(oh));
    endtask

    // Structural invariants on both instances, away from the active edge.
    always @(negedge clk) begin
        chk("inv8", 64'(bus8.gnt_onehot),
            bus8.gnt_valid ? (64'(1) << bus8.gnt_idx) : 64'(0));
        chk("inv5", 64'(bus5.gnt_onehot),
            bus5.gnt_valid ? (64'(1) << bus5.gnt_idx) : 64'(0));
        chk("inv5_range", 64'(bus5.gnt_idx < 3'd5), 64'(1));
    end

    initial begin
        logic [2:0] e;
        rst       = 1'b1;
        bus8.req  = 8'hFF;
        bus8.done = 1'b0;
        bus5.req  = 5'b0;
        bus5.done = 1'b0;

        // Reset held with all requests up
        step();
        chk8("rst1", 1'b0, 3'd0, 8'h00);
        chk("rst1.any", 64'(bus8.any_req), 64'(0));
        step();
        chk8("rst2", 1'b0, 3'd0, 8'h00);
        chk("rst2.any", 64'(bus8.any_req), 64'(0));

        rst = 1'b0;
        step();
        chk8("first", 1'b1, 3'd0, 8'h01);
        chk("first.any", 64'(bus8.any_req), 64'(1));

        // Release, then lock onto index 2
        bus8.req  = 8'h00;
        bus8.done = 1'b1;
        step();
        bus8.done = 1'b0;
        chk8("rel0", 1'b0, 3'd0, 8'h00);
        bus8.req = 8'h04;
        step();
        chk8("g2", 1'b1, 3'd2, 8'h04);
        bus8.req = 8'h01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk8("lock", 1'b1, 3'd2, 8'h04);
        end

        // Release to idle; done in idle is ignored
        bus8.req  = 8'h00;
        bus8.done = 1'b1;
        step();
        bus8.done = 1'b0;
        chk8("rel2", 1'b0, 3'd2, 8'h00);
        chk("rel2.any", 64'(bus8.any_req), 64'(0));
        bus8.done = 1'b1;
        step();
        bus8.done = 1'b0;
        chk8("idle_done", 1'b0, 3'd2, 8'h00);

        // Back-to-back re-arbitration
        bus8.req = 8'hA0;
        step();
        chk8("g5", 1'b1, 3'd5, 8'h20);
        bus8.done = 1'b1;
        step();
        bus8.done = 1'b0;
        e = RR ? 3'd7 : 3'd5;
        chk8("b2b", 1'b1, e, 8'h01 << e);
        bus8.req  = 8'h80;
        bus8.done = 1'b1;
        step();
        bus8.done = 1'b0;
        chk8("g7", 1'b1, 3'd7, 8'h80);

        // Reset mid-grant, then rotation sweep with all requesters active
        bus8.req = 8'hFF;
        rst      = 1'b1;
        step();
        chk8("rst_mid", 1'b0, 3'd0, 8'h00);
        rst = 1'b0;
        step();
        chk8("sweep0", 1'b1, 3'd0, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            e = RR ? 3'(k % 8) : 3'd0;
            bus8.done = 1'b1;
            step();
            bus8.done = 1'b0;
            chk8("sweep", 1'b1, e, 8'h01 << e);
            step();
            chk8("sweep_hold", 1'b1, e, 8'h01 << e);
        end

        // Non-power-of-two width
        bus5.req = 5'b10000;
        step();
        chk("n5.valid", 64'(bus5.gnt_valid), 64'(1));
        chk("n5.idx4", 64'(bus5.gnt_idx), 64'(4));
        chk("n5.oh4", 64'(bus5.gnt_onehot), 64'(5'b10000));
        bus5.req  = 5'h1F;
        bus5.done = 1'b1;
        step();
        chk("n5.wrap", 64'(bus5.gnt_idx), 64'(0));
        step();
        bus5.done = 1'b0;
        chk("n5.next", 64'(bus5.gnt_idx), RR ? 64'(1) : 64'(0));
        chk("n5.valid2", 64'(bus5.gnt_valid), 64'(1));

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
